// File: rtl/data_sram_rsp.sv
// ----------------------------------------------------------------------------
// data_sram_rsp
//
// Responder for the core's data-memory port with synthesizable word-organised
// backing storage. It takes one load or store at a time. Each request is held
// for LATENCY cycles. Read data is then returned through a valid/ready
// response handshake.
//
// Parameters
//   XLEN      data and address width
//   BASE_ADDR byte address mapped to word 0
//   DEPTH_W   log2 of storage depth in XLEN-bit words
//   LATENCY   cycles from request accept to response valid (1..15)
//
// Ports
//   clk        clock
//   rst_b      asynchronous, active-low reset
//   req_valid  request present
//   req_ready  responder can accept a request (IDLE and out of reset)
//   req_wen    1 = store, 0 = load
//   req_addr   byte address; bits [1:0] are ignored
//   req_wstrb  byte write enables (stores only)
//   req_wdata  store data, byte lanes aligned to the word
//   rsp_valid  response present
//   rsp_ready  requester consumes the response
//   rsp_rdata  load data (full word); 0 for stores
//   rsp_err    address out of range
//
// Build option
//   DATA_SRAM_ERR_EN  when defined, a word index of 2**DEPTH_W or more is out
//                     of range: nothing is written, the response carries
//                     rsp_rdata = 0 and rsp_err = 1. When undefined, the index
//                     is truncated to DEPTH_W bits, so addresses alias, and
//                     rsp_err is tied to 0.
//
// Storage is not reset. Writes commit at the accept edge, so a store that was
// accepted before a reset stays in memory.
// ----------------------------------------------------------------------------
module data_sram_rsp #(
    parameter int unsigned      XLEN      = 32,
    parameter logic [XLEN-1:0]  BASE_ADDR = 32'h8000_0000,
    parameter int unsigned      DEPTH_W   = 12,
    parameter int unsigned      LATENCY   = 2
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [XLEN-1:0]     req_addr,
    input  logic [XLEN/8-1:0]   req_wstrb,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [XLEN-1:0]     rsp_rdata,
    output logic                rsp_err
);

    localparam int unsigned     NB       = XLEN / 8;
    localparam int unsigned     DEPTH    = 1 << DEPTH_W;
    localparam int unsigned     CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]    rdata_q, rdata_d;
`ifdef DATA_SRAM_ERR_EN
    logic               err_q, err_d;
`endif

    logic [XLEN-1:0]    mem [DEPTH];

    logic [XLEN-1:0]    addr_off;
    logic [DEPTH_W-1:0] word_idx;
    logic               in_range;
    logic               idle_ready;
    logic               accept;
    logic               mem_we;

    // ------------------------------------------------------------------------
    // Address decode: the offset from BASE_ADDR wraps modulo 2**XLEN.
    // ------------------------------------------------------------------------
    assign addr_off = req_addr - BASE_ADDR;
    assign word_idx = addr_off[DEPTH_W+1:2];

`ifdef DATA_SRAM_ERR_EN
    // Any offset bit above the storage window marks the word as missing.
    assign in_range = (addr_off[XLEN-1:DEPTH_W+2] == '0);
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_off[1:0];
`else
    // Upper offset bits are dropped, so the window repeats across the space.
    assign in_range = 1'b1;
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_off[XLEN-1:DEPTH_W+2], addr_off[1:0]};
`endif

    // Reset is folded into ready so that no request can be taken, and no
    // storage write can occur, while rst_b is held low.
    assign idle_ready = rst_b && (state_q == ST_IDLE);
    assign accept     = idle_ready && req_valid;
    assign mem_we     = accept && req_wen && in_range;

    // ------------------------------------------------------------------------
    // Backing storage: byte-lane writes at the accept edge, no reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (req_wstrb[b]) begin
                    mem[word_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
`ifdef DATA_SRAM_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
`ifdef DATA_SRAM_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
`ifdef DATA_SRAM_ERR_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    // The load result is captured now. The word is therefore
                    // fixed at accept, independent of later inputs.
                    cnt_d   = CNT_LOAD;
                    state_d = (LATENCY > 1) ? ST_WAIT : ST_RESP;
                    rdata_d = (!req_wen && in_range) ? mem[word_idx] : '0;
`ifdef DATA_SRAM_ERR_EN
                    err_d   = !in_range;
`endif
                end
            end
            ST_WAIT: begin
                // The counter holds LATENCY-1 on entry. Leaving at 1 gives
                // LATENCY-1 wait cycles before the response cycle.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        req_ready = idle_ready;
        rsp_valid = (state_q == ST_RESP);
        rsp_rdata = rdata_q;
`ifdef DATA_SRAM_ERR_EN
        rsp_err   = err_q;
`else
        rsp_err   = 1'b0;
`endif
    end

`ifndef SYNTHESIS
    // A response held off by the requester must not change.
    a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_b)
        rsp_valid && !rsp_ready |=> rsp_valid && $stable(rsp_rdata) && $stable(rsp_err));

    // A request is never accepted while a response is outstanding.
    a_no_overlap: assert property (@(posedge clk) disable iff (!rst_b)
        !(req_ready && rsp_valid));
`endif

endmodule

// File: tb/tb_data_sram_rsp.sv
// ----------------------------------------------------------------------------
// Bench for data_sram_rsp. It uses three instances that share the request
// buses, and sel steers req_valid and the observed outputs to one of them:
//   0: LATENCY=2,  DEPTH_W=4
//   1: LATENCY=1,  DEPTH_W=12
//   2: LATENCY=15, DEPTH_W=4
// Expected read data comes from a word-addressed associative model.
// ----------------------------------------------------------------------------
module tb_data_sram_rsp;

    localparam logic [31:0] BASE = 32'h8000_0000;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        int          hold;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    logic        clk;
    logic        rst_b;
    logic        req_valid;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic        rsp_ready;
    int unsigned sel;

    logic [2:0]  rv;
    logic        rdy [3];
    logic        vld [3];
    logic [31:0] rd  [3];
    logic        er  [3];

    int checks;
    int errors;

    bit [31:0] mdl [int unsigned];

    assign rv = req_valid ? 3'(3'b001 << sel) : 3'b000;

    data_sram_rsp #(.XLEN(32), .BASE_ADDR(BASE), .DEPTH_W(4), .LATENCY(2)) u_dut0 (
        .clk(clk), .rst_b(rst_b), .req_valid(rv[0]), .req_ready(rdy[0]),
        .req_wen(req_wen), .req_addr(req_addr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .rsp_valid(vld[0]), .rsp_ready(rsp_ready), .rsp_rdata(rd[0]), .rsp_err(er[0]));

    data_sram_rsp #(.XLEN(32), .BASE_ADDR(BASE), .DEPTH_W(12), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst_b(rst_b), .req_valid(rv[1]), .req_ready(rdy[1]),
        .req_wen(req_wen), .req_addr(req_addr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .rsp_valid(vld[1]), .rsp_ready(rsp_ready), .rsp_rdata(rd[1]), .rsp_err(er[1]));

    data_sram_rsp #(.XLEN(32), .BASE_ADDR(BASE), .DEPTH_W(4), .LATENCY(15)) u_dut2 (
        .clk(clk), .rst_b(rst_b), .req_valid(rv[2]), .req_ready(rdy[2]),
        .req_wen(req_wen), .req_addr(req_addr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .rsp_valid(vld[2]), .rsp_ready(rsp_ready), .rsp_rdata(rd[2]), .rsp_err(er[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int unsigned s);
        case (s)
            0: return 2;
            1: return 1;
            default: return 15;
        endcase
    endfunction

    function automatic int unsigned dw_of(input int unsigned s);
        return (s == 1) ? 12 : 4;
    endfunction

    // Memory model: index = (addr - BASE) / 4, then either range-checked or
    // wrapped to the depth. Words never fully written are reported unknown.
    function automatic void model(input int unsigned s, input logic wen,
                                  input logic [31:0] addr, input logic [3:0] strb,
                                  input logic [31:0] wdata, output logic [31:0] rdv,
                                  output logic errv, output bit known);
        logic [31:0] idx;
        logic [31:0] mask;
        logic [31:0] cur;
        int unsigned depth;
        int unsigned key;
        depth = 1 << dw_of(s);
        idx   = (addr - BASE) / 4;
        rdv   = '0;
        known = 1'b1;
`ifdef DATA_SRAM_ERR_EN
        errv  = (idx >= depth);
`else
        errv  = 1'b0;
        idx   = idx % depth;
`endif
        if (errv) return;
        key = s * 65536 + idx;
        if (!wen) begin
            if (mdl.exists(key)) rdv = mdl[key];
            else known = 1'b0;
        end else begin
            mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
            if (strb == 4'hF) begin
                mdl[key] = wdata;
            end else if (mdl.exists(key)) begin
                cur = mdl[key];
                mdl[key] = (cur & ~mask) | (wdata & mask);
            end
        end
    endfunction

    task automatic chk(input string tag, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %h expected %h", tag, what, act, exp);
        end
    endtask

    task automatic tmo(input string tag, input string what, input int n);
        checks++;
        errors++;
        $display("FAIL %s %s: no event after %0d cycles, expected one", tag, what, n);
    endtask

    // One complete transaction on instance sel. The caller is at posedge+1.
    // hold = number of response cycles with rsp_ready low.
    task automatic txn(input logic wen, input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] wdata, input int hold, input logic [31:0] exp_rd,
                       input logic exp_err, input bit chk_rd, input string tag);
        int n;
        req_wen   = wen;
        req_addr  = addr;
        req_wstrb = strb;
        req_wdata = wdata;
        req_valid = 1'b1;
        rsp_ready = (hold == 0);
        n = 0;
        while (!rdy[sel]) begin
            @(posedge clk); #1;
            n++;
            if (n > 64) begin
                tmo(tag, "accept", n);
                req_valid = 1'b0;
                rsp_ready = 1'b1;
                return;
            end
        end
        @(posedge clk); #1;
        // Request is taken; the fields are now don't-care.
        req_valid = 1'b0;
        req_wen   = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_wstrb = 4'($urandom);
        req_wdata = $urandom;
        n = 1;
        while (!vld[sel]) begin
            chk(tag, "req_ready_busy", 32'(rdy[sel]), 32'd0);
            @(posedge clk); #1;
            n++;
            if (n > 64) begin
                tmo(tag, "rsp_valid", n);
                rsp_ready = 1'b1;
                return;
            end
        end
        chk(tag, "latency", 32'(n), 32'(lat_of(sel)));
        if (chk_rd) chk(tag, "rdata", rd[sel], exp_rd);
        chk(tag, "err", 32'(er[sel]), 32'(exp_err));
        chk(tag, "req_ready_rsp", 32'(rdy[sel]), 32'd0);
        for (int i = 1; i < hold; i++) begin
            @(posedge clk); #1;
            chk(tag, "held_valid", 32'(vld[sel]), 32'd1);
            if (chk_rd) chk(tag, "held_rdata", rd[sel], exp_rd);
            chk(tag, "held_err", 32'(er[sel]), 32'(exp_err));
            chk(tag, "held_req_ready", 32'(rdy[sel]), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk(tag, "rsp_one_cycle", 32'(vld[sel]), 32'd0);
        chk(tag, "req_ready_after", 32'(rdy[sel]), 32'd1);
    endtask

    function automatic logic [31:0] rnd_addr(input int unsigned s);
        int unsigned k;
        int unsigned r;
        logic [31:0] a;
        k = $urandom_range(0, 15);
        r = $urandom_range(0, 9);
        if (r < 7)      a = BASE + 32'(4 * k);
        else if (r < 9) a = BASE + (32'd4 << dw_of(s)) + 32'(4 * k);
        else            a = BASE - 32'(4 * (k + 1));
        return a + 32'($urandom_range(0, 3));
    endfunction

    task automatic run_random(input int unsigned s, input int n);
        logic [31:0] a, d, erd;
        logic [3:0]  st;
        logic        w, eerr;
        bit          kn;
        int          hold;
        sel = s;
        for (int k = 0; k < 16; k++) begin
            a = BASE + 32'(4 * k);
            d = $urandom;
            model(s, 1'b1, a, 4'hF, d, erd, eerr, kn);
            txn(1'b1, a, 4'hF, d, 0, erd, eerr, kn, "prewrite");
        end
        for (int i = 0; i < n; i++) begin
            w    = 1'($urandom_range(0, 1));
            a    = rnd_addr(s);
            st   = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            d    = $urandom;
            hold = $urandom_range(0, 3);
            model(s, w, a, st, d, erd, eerr, kn);
            txn(w, a, st, d, hold, erd, eerr, kn, "random");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tv[$];
        logic [31:0] erd;
        logic        eerr;
        bit          kn;

        checks    = 0;
        errors    = 0;
        sel       = 0;
        rst_b     = 1'b0;
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_addr  = '0;
        req_wstrb = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            chk("reset", "req_ready_low", 32'(rdy[s]), 32'd0);
            chk("reset", "rsp_valid", 32'(vld[s]), 32'd0);
            chk("reset", "rsp_rdata", rd[s], 32'd0);
            chk("reset", "rsp_err", 32'(er[s]), 32'd0);
        end
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        for (int s = 0; s < 3; s++) chk("reset", "req_ready_release", 32'(rdy[s]), 32'd1);
        @(posedge clk); #1;

        // ---------------- directed table on instance 0 ----------------
        tv.push_back('{1'b1, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF, 0, 32'h0, 1'b0});
        tv.push_back('{1'b0, 32'h8000_0010, 4'h0, 32'h0,         0, 32'hDEAD_BEEF, 1'b0});
        tv.push_back('{1'b1, 32'h8000_0014, 4'hF, 32'h1122_3344, 1, 32'h0, 1'b0});
        tv.push_back('{1'b1, 32'h8000_0014, 4'h2, 32'h0000_AA00, 0, 32'h0, 1'b0});
        tv.push_back('{1'b0, 32'h8000_0014, 4'h0, 32'h0,         0, 32'h1122_AA44, 1'b0});
        tv.push_back('{1'b1, 32'h8000_0014, 4'h0, 32'hFFFF_FFFF, 0, 32'h0, 1'b0});
        tv.push_back('{1'b0, 32'h8000_0014, 4'h0, 32'h0,         0, 32'h1122_AA44, 1'b0});
        tv.push_back('{1'b0, 32'h8000_0013, 4'h0, 32'h0,         5, 32'hDEAD_BEEF, 1'b0});
        tv.push_back('{1'b1, 32'h8000_0000, 4'hF, 32'hCAFE_F00D, 0, 32'h0, 1'b0});
        tv.push_back('{1'b1, 32'h8000_0004, 4'hF, 32'h1234_5678, 0, 32'h0, 1'b0});
        tv.push_back('{1'b1, 32'h8000_003C, 4'hF, 32'h0F0F_0F0F, 0, 32'h0, 1'b0});
`ifdef DATA_SRAM_ERR_EN
        tv.push_back('{1'b0, 32'h8000_0040, 4'h0, 32'h0,         0, 32'h0, 1'b1});
        tv.push_back('{1'b1, 32'h8000_0044, 4'hF, 32'hA5A5_A5A5, 0, 32'h0, 1'b1});
        tv.push_back('{1'b0, 32'h8000_0004, 4'h0, 32'h0,         0, 32'h1234_5678, 1'b0});
        tv.push_back('{1'b0, 32'h7FFF_FFFC, 4'h0, 32'h0,         0, 32'h0, 1'b1});
`else
        tv.push_back('{1'b0, 32'h8000_0040, 4'h0, 32'h0,         0, 32'hCAFE_F00D, 1'b0});
        tv.push_back('{1'b1, 32'h8000_0044, 4'hF, 32'hA5A5_A5A5, 0, 32'h0, 1'b0});
        tv.push_back('{1'b0, 32'h8000_0004, 4'h0, 32'h0,         0, 32'hA5A5_A5A5, 1'b0});
        tv.push_back('{1'b0, 32'h7FFF_FFFC, 4'h0, 32'h0,         0, 32'h0F0F_0F0F, 1'b0});
`endif
        tv.push_back('{1'b0, 32'h8000_003F, 4'h0, 32'h0,         2, 32'h0F0F_0F0F, 1'b0});

        sel = 0;
        foreach (tv[i]) begin
            model(0, tv[i].wen, tv[i].addr, tv[i].strb, tv[i].wdata, erd, eerr, kn);
            txn(tv[i].wen, tv[i].addr, tv[i].strb, tv[i].wdata, tv[i].hold,
                tv[i].exp_rd, tv[i].exp_err, 1'b1, "table");
        end

        // ---------------- reset during WAIT of a store ----------------
        req_wen   = 1'b1;
        req_addr  = 32'h8000_0020;
        req_wstrb = 4'hF;
        req_wdata = 32'h5A5A_1234;
        req_valid = 1'b1;
        chk("rst_wait", "req_ready_idle", 32'(rdy[0]), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        model(0, 1'b1, 32'h8000_0020, 4'hF, 32'h5A5A_1234, erd, eerr, kn);
        chk("rst_wait", "in_wait_valid", 32'(vld[0]), 32'd0);
        chk("rst_wait", "in_wait_ready", 32'(rdy[0]), 32'd0);
        #2 rst_b = 1'b0;
        #1;
        chk("rst_wait", "ready_in_reset", 32'(rdy[0]), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_wait", "valid_in_reset", 32'(vld[0]), 32'd0);
        end
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        chk("rst_wait", "ready_after_release", 32'(rdy[0]), 32'd1);
        @(posedge clk); #1;
        repeat (3) begin
            chk("rst_wait", "valid_after_release", 32'(vld[0]), 32'd0);
            @(posedge clk); #1;
        end
        txn(1'b0, 32'h8000_0020, 4'h0, 32'h0, 0, 32'h5A5A_1234, 1'b0, 1'b1, "rst_wait_load");

        // ---------------- randomized against the model ----------------
        run_random(0, 60);
        run_random(1, 60);

        // ---------------- LATENCY=1 back-to-back loads ----------------
        sel       = 1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            model(1, 1'b0, BASE + 32'(4 * i), 4'h0, 32'h0, erd, eerr, kn);
            req_wen   = 1'b0;
            req_addr  = BASE + 32'(4 * i);
            req_valid = 1'b1;
            chk("b2b", "req_ready_idle", 32'(rdy[1]), 32'd1);
            chk("b2b", "valid_idle", 32'(vld[1]), 32'd0);
            @(posedge clk); #1;
            chk("b2b", "req_ready_rsp", 32'(rdy[1]), 32'd0);
            chk("b2b", "valid_rsp", 32'(vld[1]), 32'd1);
            if (kn) chk("b2b", "rdata", rd[1], erd);
            req_addr = $urandom;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;

        // ---------------- LATENCY=15 ----------------
        run_random(2, 20);

        // ---------------- reset during RESP (LATENCY=15) ----------------
        sel       = 2;
        rsp_ready = 1'b0;
        req_wen   = 1'b0;
        req_addr  = BASE;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        begin
            int n;
            n = 0;
            while (!vld[2] && n < 64) begin
                @(posedge clk); #1;
                n++;
            end
            if (!vld[2]) tmo("rst_resp", "rsp_valid", n);
        end
        #2 rst_b = 1'b0;
        #1;
        chk("rst_resp", "valid_in_reset", 32'(vld[2]), 32'd0);
        chk("rst_resp", "rdata_in_reset", rd[2], 32'd0);
        @(negedge clk);
        rst_b     = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("rst_resp", "ready_after", 32'(rdy[2]), 32'd1);
        chk("rst_resp", "valid_after", 32'(vld[2]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
